// File: rtl/conv_layer_sequencer_if.sv
// Sequencer-to-datapath bundle: sample clock and layer handshake in, pulses, index and status out.
// Define SEQ_PERF_EN to add the last_cycles performance output.
interface conv_layer_sequencer_if #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    logic             sample_clk;
    logic             conv_done;
    logic             lsb_shift;
    logic             conv_rst;
    logic             conv_start;
    logic [IDX_W-1:0] layer_idx;
    logic             out_latch;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] n_sample_ticks;
    logic [CNT_W-1:0] n_overruns;
`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] last_cycles;

    modport master (
        input  sample_clk, conv_done,
        output lsb_shift, conv_rst, conv_start, layer_idx, out_latch, busy,
               timeout_err, n_sample_ticks, n_overruns, last_cycles
    );
    modport slave (
        output sample_clk, conv_done,
        input  lsb_shift, conv_rst, conv_start, layer_idx, out_latch, busy,
               timeout_err, n_sample_ticks, n_overruns, last_cycles
    );
`else
    modport master (
        input  sample_clk, conv_done,
        output lsb_shift, conv_rst, conv_start, layer_idx, out_latch, busy,
               timeout_err, n_sample_ticks, n_overruns
    );
    modport slave (
        output sample_clk, conv_done,
        input  lsb_shift, conv_rst, conv_start, layer_idx, out_latch, busy,
               timeout_err, n_sample_ticks, n_overruns
    );
`endif
endinterface

// File: rtl/conv_layer_sequencer.sv
// Per-sample scheduler: shift buffer pulse, then reset/start/done handshake for each conv layer, then output latch.
// Optional macro SEQ_PERF_EN adds a cycle count of the last completed sequence (last_cycles).
module conv_layer_sequencer #(
    parameter int NUM_LAYERS     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = 4,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_layer_sequencer_if.master seq
);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LAYERS - 1);
    localparam logic [TCNT_W-1:0] T_LIMIT  = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAITING     = 3'd0,
        S_SHIFT       = 3'd1,
        S_RST_LAYER   = 3'd2,
        S_START_LAYER = 3'd3,
        S_RUN         = 3'd4,
        S_OUTPUT      = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic              prev_sc_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  ticks_q, ticks_d;
    logic [CNT_W-1:0]  ovr_q, ovr_d;
    logic              lsb_q, crst_q, cstart_q, olatch_q, busy_q;
    logic              sample_edge;

    // Next-state, layer index, timeout and counter update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        ticks_d     = ticks_q;
        ovr_d       = ovr_q;
        sample_edge = seq.sample_clk & ~prev_sc_q;

        // Edges are only accepted from WAITING; any other state counts them as overruns
        if (sample_edge && (state_q == S_WAITING)) begin
            ticks_d = ticks_q + CNT_W'(1);
        end else if (sample_edge && (ovr_q != {CNT_W{1'b1}})) begin
            ovr_d = ovr_q + CNT_W'(1);
        end else begin
            ovr_d = ovr_q;
        end

        case (state_q)
            S_WAITING: begin
                if (sample_edge) begin
                    state_d = S_SHIFT;
                    idx_d   = '0;
                end else begin
                    state_d = S_WAITING;
                end
            end
            S_SHIFT:     state_d = S_RST_LAYER;
            S_RST_LAYER: state_d = S_START_LAYER;
            S_START_LAYER: begin
                state_d = S_RUN;
                tcnt_d  = '0;
            end
            S_RUN: begin
                if (seq.conv_done && (idx_q == LAST_IDX)) begin
                    state_d = S_OUTPUT;
                end else if (seq.conv_done) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_RST_LAYER;
                end else if (tcnt_q == T_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_WAITING;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            S_OUTPUT: state_d = S_WAITING;
            default:  state_d = S_WAITING;
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAITING;
            prev_sc_q <= 1'b0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
            ticks_q   <= '0;
            ovr_q     <= '0;
            lsb_q     <= 1'b0;
            crst_q    <= 1'b0;
            cstart_q  <= 1'b0;
            olatch_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_sc_q <= seq.sample_clk;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
            ticks_q   <= ticks_d;
            ovr_q     <= ovr_d;
            lsb_q     <= (state_d == S_SHIFT);
            crst_q    <= (state_d == S_RST_LAYER);
            cstart_q  <= (state_d == S_START_LAYER);
            olatch_q  <= (state_d == S_OUTPUT);
            busy_q    <= (state_d != S_WAITING);
        end
    end

    assign seq.lsb_shift      = lsb_q;
    assign seq.conv_rst       = crst_q;
    assign seq.conv_start     = cstart_q;
    assign seq.layer_idx      = idx_q;
    assign seq.out_latch      = olatch_q;
    assign seq.busy           = busy_q;
    assign seq.timeout_err    = err_q;
    assign seq.n_sample_ticks = ticks_q;
    assign seq.n_overruns     = ovr_q;

`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] perf_q, last_q;
    logic [CNT_W:0]   perf_total;

    // perf_q is 0 during SHIFT, so the length at OUTPUT entry is perf_q plus this cycle plus OUTPUT
    always_comb begin
        perf_total = {1'b0, perf_q} + (CNT_W + 1)'(2);
    end

    // Sequence length counter and snapshot on successful completion
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
            last_q <= '0;
        end else begin
            if (state_d == S_SHIFT) begin
                perf_q <= '0;
            end else if ((state_q != S_WAITING) && (perf_q != {CNT_W{1'b1}})) begin
                perf_q <= perf_q + CNT_W'(1);
            end else begin
                perf_q <= perf_q;
            end
            if (state_d == S_OUTPUT) begin
                last_q <= perf_total[CNT_W] ? {CNT_W{1'b1}} : perf_total[CNT_W-1:0];
            end else begin
                last_q <= last_q;
            end
        end
    end

    assign seq.last_cycles = last_q;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: directed scenarios with literal expectations plus random stimulus
// checked every cycle against a cycle-arithmetic model of the sequence schedule.
module tb_conv_layer_sequencer;
    localparam int NL   = 2;
    localparam int TO   = 8;
    localparam int IW   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   t        = 0;

    conv_layer_sequencer_if #(.IDX_W(IW), .CNT_W(CW)) bus();

    conv_layer_sequencer #(
        .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .IDX_W(IW), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .seq(bus)
    );

    always #5 clk = ~clk;

    // Literal expectations posted by the directed scenarios for the current cycle
    logic  lit_pulse_en = 1'b0, lit_cnt_en = 1'b0, lit_err_en = 1'b0, lit_idx_en = 1'b0;
    logic  lit_lsb, lit_rst, lit_start, lit_out, lit_busy, lit_err;
    int    lit_ticks, lit_ovr, lit_idx;
    string lit_name = "";
`ifdef SEQ_PERF_EN
    logic  lit_last_en = 1'b0;
    int    lit_last;
`endif

    // Model: inputs as sampled by the DUT at this cycle's posedge (captured at the previous negedge)
    logic s_sc = 1'b0, s_done = 1'b0, s_rst = 1'b1;
    logic m_prev = 1'b0, m_active = 1'b0, m_err = 1'b0;
    int   m_ticks = 0, m_ovr = 0, m_idx = 0;
    int   m_shift = -100, m_rst_cyc = -100, m_out_cyc = -1, m_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic busy_prev;
        logic edge_seen;
        busy_prev = m_active;
        if (s_rst) begin
            m_prev = 1'b0; m_active = 1'b0; m_err = 1'b0;
            m_ticks = 0; m_ovr = 0; m_idx = 0; m_out_cyc = -1; m_last = 0;
        end else begin
            edge_seen = s_sc && !m_prev;
            m_prev    = s_sc;
            if (m_active) begin
                if (t - 1 == m_out_cyc) begin
                    m_active = 1'b0;
                end else if (t - 1 >= m_rst_cyc + 2) begin
                    if (s_done && m_idx == NL - 1) begin
                        m_out_cyc = t;
                        m_last    = (t - m_shift + 1 > CMAX) ? CMAX : t - m_shift + 1;
                    end else if (s_done) begin
                        m_idx++;
                        m_rst_cyc = t;
                    end else if ((t - 1) - (m_rst_cyc + 2) == TO - 1) begin
                        m_err    = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
            if (edge_seen && busy_prev) begin
                m_ovr = (m_ovr == CMAX) ? CMAX : m_ovr + 1;
            end else if (edge_seen) begin
                m_ticks   = (m_ticks + 1) % (CMAX + 1);
                m_active  = 1'b1;
                m_shift   = t;
                m_rst_cyc = t + 1;
                m_idx     = 0;
                m_out_cyc = -1;
            end
        end

        chk("lsb_shift",   32'(bus.lsb_shift),   32'(m_active && t == m_shift));
        chk("conv_rst",    32'(bus.conv_rst),    32'(m_active && t == m_rst_cyc));
        chk("conv_start",  32'(bus.conv_start),  32'(m_active && t == m_rst_cyc + 1));
        chk("out_latch",   32'(bus.out_latch),   32'(m_active && t == m_out_cyc));
        chk("busy",        32'(bus.busy),        32'(m_active));
        chk("layer_idx",   32'(bus.layer_idx),   32'(m_idx));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
        chk("ticks",       32'(bus.n_sample_ticks), 32'(m_ticks));
        chk("overruns",    32'(bus.n_overruns),  32'(m_ovr));
`ifdef SEQ_PERF_EN
        chk("last_cycles", 32'(bus.last_cycles), 32'(m_last));
        if (lit_last_en) chk({lit_name, "_last"}, 32'(bus.last_cycles), 32'(lit_last));
`endif

        if (lit_pulse_en) begin
            chk({lit_name, "_lsb"},   32'(bus.lsb_shift),  32'(lit_lsb));
            chk({lit_name, "_rst"},   32'(bus.conv_rst),   32'(lit_rst));
            chk({lit_name, "_start"}, 32'(bus.conv_start), 32'(lit_start));
            chk({lit_name, "_out"},   32'(bus.out_latch),  32'(lit_out));
            chk({lit_name, "_busy"},  32'(bus.busy),       32'(lit_busy));
        end
        if (lit_cnt_en) begin
            chk({lit_name, "_ticks"}, 32'(bus.n_sample_ticks), 32'(lit_ticks));
            chk({lit_name, "_ovr"},   32'(bus.n_overruns),     32'(lit_ovr));
        end
        if (lit_err_en) chk({lit_name, "_err"}, 32'(bus.timeout_err), 32'(lit_err));
        if (lit_idx_en) chk({lit_name, "_idx"}, 32'(bus.layer_idx),   32'(lit_idx));

        s_sc   = bus.sample_clk;
        s_done = bus.conv_done;
        s_rst  = rst;
        t++;
    end

    task automatic drive(input logic sc, input logic dn, input logic r);
        @(posedge clk);
        #2;
        bus.sample_clk = sc;
        bus.conv_done  = dn;
        rst            = r;
        lit_pulse_en = 1'b0; lit_cnt_en = 1'b0; lit_err_en = 1'b0; lit_idx_en = 1'b0;
`ifdef SEQ_PERF_EN
        lit_last_en = 1'b0;
`endif
    endtask

    task automatic pulses(input string nm, input logic l, input logic r, input logic s,
                          input logic o, input logic b);
        lit_name = nm; lit_pulse_en = 1'b1;
        lit_lsb = l; lit_rst = r; lit_start = s; lit_out = o; lit_busy = b;
    endtask

    task automatic counts(input string nm, input int tk, input int ov);
        lit_name = nm; lit_cnt_en = 1'b1; lit_ticks = tk; lit_ovr = ov;
    endtask

    initial begin
        logic sc;
        rst = 1'b1;
        bus.sample_clk = 1'b0;
        bus.conv_done  = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        counts("reset", 0, 0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // Normal two-layer run with a second edge at k+5 (overrun)
        for (int j = 0; j <= 14; j++) begin
            drive(j == 0 || j == 5, j == 8 || j == 11, 1'b0);
            pulses("normal", j == 1, j == 2 || j == 9, j == 3 || j == 10, j == 12, j >= 1 && j <= 12);
            lit_idx_en = (j == 9); lit_idx = 1;
`ifdef SEQ_PERF_EN
            lit_last_en = (j == 14); lit_last = 12;
`endif
        end
        counts("normal_cnt", 1, 1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        counts("next_edge", 2, 1);
        repeat (10) drive(1'b0, 1'b1, 1'b0);

        // conv_done arriving together with the timeout limit
        for (int j = 0; j <= 16; j++) begin
            drive(j == 0, j == 11 || j == 14, 1'b0);
            pulses("done_at_limit", j == 1, j == 2 || j == 12, j == 3 || j == 13, j == 15, j >= 1 && j <= 15);
            lit_err_en = 1'b1; lit_err = 1'b0;
        end

        // conv_done held high from k+1 is ignored until RUN
        for (int j = 0; j <= 10; j++) begin
            drive(j == 0, j >= 1, 1'b0);
            pulses("spurious", j == 1, j == 2 || j == 5, j == 3 || j == 6, j == 8, j >= 1 && j <= 8);
        end

        // Timeout: no conv_done at all
        for (int j = 0; j <= 13; j++) begin
            drive(j == 0, 1'b0, 1'b0);
            pulses("timeout", j == 1, j == 2, j == 3, 1'b0, j >= 1 && j <= 11);
            lit_err_en = 1'b1; lit_err = (j >= 12);
        end
        for (int j = 0; j <= 9; j++) begin
            drive(j == 0, j >= 1, 1'b0);
            pulses("after_timeout", j == 1, j == 2 || j == 5, j == 3 || j == 6, j == 8, j >= 1 && j <= 8);
            lit_err_en = 1'b1; lit_err = 1'b1;
        end

        // Reset mid-run, then 17 accepted edges wrap the 4-bit tick counter
        for (int j = 0; j <= 15; j++) begin
            drive(j == 0, 1'b0, j == 6);
            if (j >= 7) pulses("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            lit_err_en = (j == 7); lit_err = 1'b0;
            if (j == 7) counts("mid_reset_cnt", 0, 0);
        end
        for (int e = 0; e < 17; e++) begin
            for (int j = 0; j <= 11; j++) begin
                drive(j == 0, 1'b1, 1'b0);
                if (e == 0 && j == 11) counts("fresh_seq", 1, 0);
            end
        end
        counts("tick_wrap", 1, 0);

        // Overrun saturation: edges every other cycle during timed-out sequences
        for (int j = 0; j < 120; j++) drive(j % 2 == 0, 1'b0, 1'b0);
        lit_name = "ovr_sat"; lit_cnt_en = 1'b1; lit_ticks = bus.n_sample_ticks; lit_ovr = CMAX;
        lit_cnt_en = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        lit_name = "ovr_sat"; lit_cnt_en = 1'b1; lit_ticks = m_ticks; lit_ovr = CMAX;
        for (int j = 0; j < 20; j++) drive(j % 2 == 0, 1'b0, 1'b0);
        lit_name = "ovr_hold"; lit_cnt_en = 1'b1; lit_ticks = m_ticks; lit_ovr = CMAX;

        // Random traffic against the model
        sc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) sc = ~sc;
            drive(sc, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Per-sample scheduler for the inference network. On each rising edge of sample_clk it:
- pulses the left shift buffer once;
- steps NUM_LAYERS conv layers in order through a reset/start/done handshake on a shared layer-select bus;
- pulses an output-latch strobe when the last layer completes.

It sits between the codec sample clock and the network datapath. It replaces ad-hoc state inside the network top.

Parameters:
NUM_LAYERS, 2, number of conv layers sequenced per sample (1..16)
TIMEOUT_CYCLES, 1024, max clk cycles to wait for conv_done per layer (>=2)
IDX_W, 4, width of layer index bus; must satisfy 2**IDX_W >= NUM_LAYERS
CNT_W, 16, width of the sample and overrun counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_clk  in  1  audio sample clock, already in clk domain; the rising edge starts a sequence
conv_done  in  1  active layer finished; sampled only in RUN
lsb_shift  out  1  one-cycle pulse, clocks left shift buffer
conv_rst  out  1  one-cycle pulse, resets the layer selected by layer_idx
conv_start  out  1  one-cycle pulse, starts the layer selected by layer_idx
layer_idx  out  IDX_W  active layer index
out_latch  out  1  one-cycle pulse, network outputs valid and to be registered
busy  out  1  high in any state other than WAITING
timeout_err  out  1  sticky; set on a layer timeout, cleared only by rst
n_sample_ticks  out  CNT_W  count of accepted sample edges, wraps
n_overruns  out  CNT_W  count of sample edges seen while busy, saturates at all-ones

Behaviour:
- Edge detect:
  - prev_sample_clk register; edge = sample_clk & ~prev_sample_clk, evaluated every clk.
  - prev_sample_clk is reset to 0.
- Reset values: state=WAITING, all pulses 0, layer_idx=0, busy=0, timeout_err=0, both counters 0, timeout counter 0.
- Reset mid-sequence: sequence is abandoned at the next edge; no further pulses are emitted.
- All outputs are registered Moore decodes of state. Each pulse lasts exactly one clk.
- States and transitions:
  - WAITING: on edge -> SHIFT; n_sample_ticks+1.
  - SHIFT: lsb_shift=1; layer_idx<=0; -> RST_LAYER.
  - RST_LAYER: conv_rst=1 -> START_LAYER.
  - START_LAYER: conv_start=1; timeout counter<=0 -> RUN.
  - RUN: wait for conv_done.
    - On conv_done, if layer_idx==NUM_LAYERS-1 -> OUTPUT.
    - On conv_done otherwise, layer_idx+1 -> RST_LAYER.
    - Without conv_done, timeout counter+1.
    - If the counter reaches TIMEOUT_CYCLES-1 without conv_done: timeout_err<=1 -> WAITING, with no out_latch and remaining layers skipped.
    - conv_done and the timeout limit in the same cycle: done wins.
  - OUTPUT: out_latch=1 -> WAITING.
- Latency: edge detected at posedge k gives the following sequence.
  - lsb_shift high in cycle k+1, conv_rst k+2, conv_start k+3, RUN from k+4.
  - Each subsequent layer adds 3 cycles plus its done wait.
  - out_latch is high the cycle after the final accepted conv_done.
- conv_done outside RUN is ignored; it is not stored.
- Overrun: an edge while busy (any state except WAITING) is dropped.
  - n_overruns increments, saturating; n_sample_ticks is unchanged; the sequence continues.
  - An edge in the same cycle as the OUTPUT->WAITING transition counts as an overrun.
  - An edge in the first WAITING cycle is accepted.
- Counters: n_sample_ticks wraps modulo 2**CNT_W. n_overruns sticks at 2**CNT_W-1.
- timeout_err does not block later sequences. Subsequent edges run normally.

Optional Feature:
Macro SEQ_PERF_EN.
- Defined:
  - Adds output last_cycles [CNT_W-1:0], reset 0.
  - An internal counter clears in SHIFT and increments every clk while busy.
  - On entering OUTPUT, last_cycles<=counter+1, i.e. cycles from SHIFT through OUTPUT inclusive, saturating at all-ones.
  - Not updated on timeout.
- Undefined: no port, no counter logic.

Test Plan:
- Normal run, NUM_LAYERS=2: edge at k, conv_done in cycles k+8 and k+11.
  - Expected: lsb_shift@k+1; conv_rst@k+2 (idx0); start@k+3; conv_rst@k+9 (idx1); start@k+10; out_latch@k+12; busy low @k+13; n_sample_ticks=1.
  - With SEQ_PERF_EN, last_cycles=12.
- Overrun: second rising edge at k+5 during the run above.
  - Expected: n_overruns=1, n_sample_ticks=1, sequence timing unchanged.
  - Next edge after WAITING is accepted; n_sample_ticks=2.
- Timeout with TIMEOUT_CYCLES=8: never assert conv_done.
  - Expected: timeout_err=1 with state WAITING 8 cycles after RUN entry; no out_latch.
  - Next edge runs normally and timeout_err stays 1.
- Spurious/simultaneous done:
  - conv_done held high from k+1: ignored through START_LAYER; accepted on the first RUN cycle k+4.
  - Done together with the timeout limit: layer advances and timeout_err=0.
- Reset mid-run: assert rst at k+6 for 1 cycle.
  - Expected: all outputs at reset values next cycle; no pulses afterwards; the next edge starts a fresh sequence with n_sample_ticks=1.
- Counter saturation, CNT_W=4: force 20 overruns.
  - Expected: n_overruns=15 and holds.
  - 17 accepted edges give n_sample_ticks=1 (wrapped).
